// File: rtl/vrf_wb_arbiter.sv
// Result write-back arbiter: buffers ALU/MFPU writes in 2-entry FIFOs and round-robins
// them onto one registered VRF write port. Define ARA_VRF_WB_PERF_EN for wb_stall_cnt_o.
module vrf_wb_arbiter #(
   parameter  int unsigned NrVInsn   = 8,
   parameter  int unsigned AddrWidth = 10,
   parameter  int unsigned DataWidth = 64,
   localparam int unsigned IdWidth   = $clog2(NrVInsn),
   localparam int unsigned StrbWidth = DataWidth / 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 alu_result_req_i,
   input  logic [IdWidth-1:0]   alu_result_id_i,
   input  logic [AddrWidth-1:0] alu_result_addr_i,
   input  logic [DataWidth-1:0] alu_result_wdata_i,
   input  logic [StrbWidth-1:0] alu_result_be_i,
   output logic                 alu_result_gnt_o,
   input  logic                 mfpu_result_req_i,
   input  logic [IdWidth-1:0]   mfpu_result_id_i,
   input  logic [AddrWidth-1:0] mfpu_result_addr_i,
   input  logic [DataWidth-1:0] mfpu_result_wdata_i,
   input  logic [StrbWidth-1:0] mfpu_result_be_i,
   output logic                 mfpu_result_gnt_o,
   output logic                 vrf_req_o,
   output logic                 vrf_src_o,
   output logic [IdWidth-1:0]   vrf_id_o,
   output logic [AddrWidth-1:0] vrf_addr_o,
   output logic [DataWidth-1:0] vrf_wdata_o,
   output logic [StrbWidth-1:0] vrf_be_o,
   input  logic                 vrf_gnt_i,
   output logic [31:0]          wb_stall_cnt_o
);

   localparam int unsigned NrSrc = 2;

   typedef enum logic {
      SRC_ALU  = 1'b0,
      SRC_MFPU = 1'b1
   } src_e;

   typedef struct packed {
      logic [IdWidth-1:0]   id;
      logic [AddrWidth-1:0] addr;
      logic [DataWidth-1:0] wdata;
      logic [StrbWidth-1:0] be;
   } wr_t;

   wr_t              in_pl    [NrSrc];
   wr_t              fifo_mem [NrSrc][2];
   logic [1:0]       cnt_q    [NrSrc];
   logic [NrSrc-1:0] in_req;
   logic [NrSrc-1:0] push;
   logic [NrSrc-1:0] pop;
   logic [NrSrc-1:0] full;
   logic [NrSrc-1:0] nempty;
   logic [NrSrc-1:0] wptr_q;
   logic [NrSrc-1:0] rptr_q;
   src_e             last_served_q;
   src_e             sel;
   logic             load;
   wr_t              head;

   always_comb begin
      in_req   = {mfpu_result_req_i, alu_result_req_i};
      in_pl[0] = '{id: alu_result_id_i, addr: alu_result_addr_i,
                   wdata: alu_result_wdata_i, be: alu_result_be_i};
      in_pl[1] = '{id: mfpu_result_id_i, addr: mfpu_result_addr_i,
                   wdata: mfpu_result_wdata_i, be: mfpu_result_be_i};
   end

   // Grant depends only on the FIFO being full, never on a same-cycle pop.
   always_comb begin
      full   = '0;
      nempty = '0;
      push   = '0;
      for (int unsigned s = 0; s < NrSrc; s++) begin
         full[s]   = (cnt_q[s] == 2'd2);
         nempty[s] = (cnt_q[s] != 2'd0);
         push[s]   = in_req[s] & ~full[s];
      end
   end

   assign alu_result_gnt_o  = push[0];
   assign mfpu_result_gnt_o = push[1];

   always_comb begin
      load = ~vrf_req_o | vrf_gnt_i;
      sel  = SRC_ALU;
      if (nempty[1] && (!nempty[0] || last_served_q == SRC_ALU)) begin
         sel = SRC_MFPU;
      end
      pop    = '0;
      pop[0] = load & nempty[0] & (sel == SRC_ALU);
      pop[1] = load & nempty[1] & (sel == SRC_MFPU);
      head   = (sel == SRC_MFPU) ? fifo_mem[1][rptr_q[1]] : fifo_mem[0][rptr_q[0]];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int unsigned s = 0; s < NrSrc; s++) begin
            cnt_q[s] <= '0;
            for (int unsigned e = 0; e < 2; e++) begin
               fifo_mem[s][e] <= '0;
            end
         end
      end else begin
         for (int unsigned s = 0; s < NrSrc; s++) begin
            if (push[s]) begin
               fifo_mem[s][wptr_q[s]] <= in_pl[s];
               wptr_q[s]              <= ~wptr_q[s];
            end
            if (pop[s]) begin
               rptr_q[s] <= ~rptr_q[s];
            end
            cnt_q[s] <= cnt_q[s] + {1'b0, push[s]} - {1'b0, pop[s]};
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vrf_req_o     <= 1'b0;
         vrf_src_o     <= 1'b0;
         vrf_id_o      <= '0;
         vrf_addr_o    <= '0;
         vrf_wdata_o   <= '0;
         vrf_be_o      <= '0;
         last_served_q <= SRC_MFPU;
      end else if (load) begin
         vrf_req_o <= |nempty;
         if (|nempty) begin
            vrf_src_o     <= sel;
            vrf_id_o      <= head.id;
            vrf_addr_o    <= head.addr;
            vrf_wdata_o   <= head.wdata;
            vrf_be_o      <= head.be;
            last_served_q <= sel;
         end
      end
   end

`ifdef ARA_VRF_WB_PERF_EN
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
      end else if (vrf_req_o && !vrf_gnt_i && stall_cnt_q != '1) begin
         stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign wb_stall_cnt_o = stall_cnt_q;
`else
   assign wb_stall_cnt_o = '0;
`endif

   a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (vrf_req_o && !vrf_gnt_i) |=> (vrf_req_o &&
         $stable({vrf_src_o, vrf_id_o, vrf_addr_o, vrf_wdata_o, vrf_be_o})));

   a_alu_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_q[0] <= 2'd2);

   a_mfpu_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_q[1] <= 2'd2);

endmodule
